// File: rtl/async_counter_if.sv
// rtl/async_counter_if.sv - heartbeat output bundle for the ripple counter
interface async_counter_if;
  logic led;

  modport master (output led);
  modport slave  (input  led);
endinterface

// File: rtl/async_counter.sv
// rtl/async_counter.sv - ripple up-counter heartbeat; ASYNC_COUNTER_SYNC_LED_EN adds a 2-flop led synchronizer
module async_counter_tff (
  input  logic clk,
  input  logic rst,
  output logic q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= ~q;
  end
endmodule

module async_counter #(
  parameter int WIDTH   = 27,
  parameter int LED_BIT = WIDTH - 1
) (
  input  logic            clk,
  input  logic            rst,
  async_counter_if.master hb
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] stage_clk;

  // Each stage advances when the previous one falls, i.e. on the rising edge of its inverse.
  assign stage_clk[0] = clk;

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign stage_clk[i] = ~q[i-1];
    end
    async_counter_tff u_tff (
      .clk (stage_clk[i]),
      .rst (rst),
      .q   (q[i])
    );
  end

`ifdef ASYNC_COUNTER_SYNC_LED_EN
  logic [1:0] led_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led_sync <= 2'b00;
    else      led_sync <= {led_sync[0], q[LED_BIT]};
  end

  assign hb.led = led_sync[1];
`else
  assign hb.led = q[LED_BIT];
`endif
endmodule

// File: tb/tb_async_counter.sv
// tb/tb_async_counter.sv - directed self-checking bench for async_counter
module tb_async_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_q  = 4'd0;
  logic       exp_s1 = 1'b0, exp_s2 = 1'b0;
  logic       exp_t1 = 1'b0, exp_t2 = 1'b0;
  time        edge_t, last4, last0;
  bit         have4 = 0, have0 = 0, prev4 = 0, prev0 = 0;

  async_counter_if hb4 ();
  async_counter_if hb0 ();

  async_counter #(.WIDTH(4), .LED_BIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .hb  (hb4.master)
  );

  async_counter #(.WIDTH(4), .LED_BIT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .hb  (hb0.master)
  );

  always #5 clk = ~clk;

  function automatic logic led4_exp();
`ifdef ASYNC_COUNTER_SYNC_LED_EN
    return exp_s2;
`else
    return exp_q[3];
`endif
  endfunction

  function automatic logic led0_exp();
`ifdef ASYNC_COUNTER_SYNC_LED_EN
    return exp_t2;
`else
    return exp_q[0];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q  = 4'd0;
    exp_s1 = 1'b0; exp_s2 = 1'b0;
    exp_t1 = 1'b0; exp_t2 = 1'b0;
    have4  = 0;    have0  = 0;
    prev4  = 0;    prev0  = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_t = $time;
    if (rst) begin
      exp_s2 = exp_s1; exp_s1 = exp_q[3];
      exp_t2 = exp_t1; exp_t1 = exp_q[0];
      exp_q  = exp_q + 4'd1;
    end
    #1;
    check("q",    32'(dut.q),  32'(exp_q));
    check("led",  32'(hb4.led), 32'(led4_exp()));
    check("led0", 32'(hb0.led), 32'(led0_exp()));
    if (hb4.led && !prev4) begin
      if (have4) check("led_period", 32'(edge_t - last4), 32'd160);
      last4 = edge_t;
      have4 = 1;
    end
    if (hb0.led && !prev0) begin
      if (have0) check("led0_period", 32'(edge_t - last0), 32'd20);
      last0 = edge_t;
      have0 = 1;
    end
    prev4 = hb4.led;
    prev0 = hb0.led;
  endtask

  initial begin
    #2;
    check("rst_q",   32'(dut.q),   32'd0);
    check("rst_led", 32'(hb4.led), 32'd0);

    repeat (3) tick();

    @(negedge clk);
    rst = 1'b1;
    repeat (27) tick();
    check("q_at_11", 32'(dut.q), 32'd11);

    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_q",    32'(dut.q),   32'd0);
    check("async_led",  32'(hb4.led), 32'd0);
    check("async_led0", 32'(hb0.led), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    tick();
    check("restart_q", 32'(dut.q), 32'd1);
    repeat (11) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
